sd_boot_sequencer: RTL
======================

# sd_boot_sequencer

Boot-time scheduler for the SPI SD read engine. After power-up it walks a contiguous image on the SD card one 32-bit word at a time, drives the SD engine's address and request lines, writes each returned word into the program memory, and holds the processor in reset until the image is loaded. Per-word timeout and retry cover a stalled card. It sits between the SD SPI controller and the instruction memory write port.

## Interface
- ADDR_STEP, 4: SD address increment per word.
- MEM_AW, 12: memory word-address width.
- TIMEOUT_CYC, 20'd500000: cycles to wait for `rd_ack_i` before a retry.
- MAX_RETRY, 3: retries allowed per word before the error state.
- boot_clk_i  in  1  single clock, all logic on rising edge
- boot_rst_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  pulse; begins load when idle
- base_addr_i  in  32  SD address of first word, sampled on start
- word_count_i  in  MEM_AW+1  words to load, sampled on start
- rd_req_o  out  1  read request to SD engine (level)
- rd_addr_o  out  32  SD address for current request
- rd_ack_i  in  1  one-cycle pulse: `rd_data_i`/`rd_err_i` valid
- rd_data_i  in  32  returned word
- rd_err_i  in  1  engine reported bad response token
- mem_we_o  out  1  memory write strobe, one cycle per word
- mem_addr_o  out  MEM_AW  memory word address
- mem_data_o  out  32  memory write data
- busy_o, done_o, error_o  out  1 each  status
- cpu_rst_n_o  out  1  processor reset; low until done
- checksum_o  out  32  running checksum (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, WRITE, NEXT, DONE, ERR.
- IDLE: on `start_i`, latch the base address, the count, and clear the word index, retry count, and checksum. If count==0, go to DONE. Otherwise go to REQ. `start_i` is ignored outside IDLE, DONE, and ERR. In DONE or ERR, `start_i` restarts the load.
- REQ: `rd_req_o`=1, `rd_addr_o`=base+index*ADDR_STEP (32-bit, wraps modulo 2^32). Clear the timeout counter, then go to WAIT.
- WAIT: `rd_req_o` stays 1. Outcomes:
  - `rd_ack_i` with `rd_err_i`=0: capture data, go to WRITE.
  - `rd_ack_i` with `rd_err_i`=1, or timeout counter reaching TIMEOUT_CYC-1: increment retry. If retry already equals MAX_RETRY, go to ERR; otherwise go to REQ (`rd_req_o` drops for that cycle).
  - If an ack and the timeout occur in the same cycle, the ack wins.
- WRITE: `mem_we_o`=1, `mem_addr_o`=index, `mem_data_o`=word. Update the checksum, then go to NEXT.
- NEXT: index+1 and retry=0. If index+1==count, go to DONE; otherwise go to REQ.
- DONE: `done_o`=1, `cpu_rst_n_o`=1. Hold until reset or restart.
- ERR: `error_o`=1, `cpu_rst_n_o`=0.
- `busy_o`=1 in REQ, WAIT, WRITE, NEXT.

## Timing
- Reset values:
  - all outputs 0, including `cpu_rst_n_o`=0 and `checksum_o`=0.
  - `rd_addr_o`=0, `mem_addr_o`=0.
  - state IDLE.
- Reset asserted mid-load aborts immediately; no further `mem_we_o`.
- `start_i` to first `rd_req_o`=1: 1 cycle.
- `rd_ack_i` to `mem_we_o`: 1 cycle. Ack to the next `rd_req_o` rise: 3 cycles.
- `rd_ack_i` is only honoured in WAIT; acks in any other state are dropped.
- Last `mem_we_o` to `done_o`/`cpu_rst_n_o` high: 2 cycles.
- Timeout counter is 20 bits and saturates; it does not wrap.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - `checksum_o` accumulates the 32-bit wrapping sum of words 0..count-2.
  - The final word is the expected sum. It is still written to memory.
  - Mismatch goes to ERR instead of DONE.
  - count==1 compares against 0.
- `BOOT_CHECKSUM_EN` undefined: `checksum_o` is tied to 0, there is no compare, and the checksum adder is absent.

## Test plan
- Base 0x00001000, count 4, engine acks after 10 cycles with 0x11,0x22,0x33,0x44:
  - `rd_addr_o` steps 0x1000/0x1004/0x1008/0x100C.
  - Memory addresses 0..3 receive 0x11..0x44.
  - `done_o` and `cpu_rst_n_o` go high; `rd_req_o` drops.
- count 0: `done_o` rises 1 cycle after `start_i`, and no `rd_req_o` is issued.
- Engine silent, TIMEOUT_CYC 16, MAX_RETRY 3: four requests to the same address, then `error_o`=1 and `cpu_rst_n_o`=0.
- `rd_err_i`=1 on the first ack of word 1, clean on the second: word 1 is written once, the load completes, and the retry count resets for word 2.
- Reset pulse during WAIT of word 2: all outputs return to reset values. A following `start_i` reloads from base.
- With `BOOT_CHECKSUM_EN`, words 5,7,12: DONE. With final word 13: ERR, and `checksum_o`=12.

Source files
------------

// File: rtl/sd_boot_sequencer_if.sv
// -----------------------------------------------------------------------------
// sd_boot_sequencer_if
//
// Bundles the two buses the boot sequencer sits between:
//   * the SD SPI read engine request/acknowledge handshake
//       rd_req_o, rd_addr_o       sequencer -> engine
//       rd_ack_i, rd_data_i,
//       rd_err_i                  engine -> sequencer
//   * the instruction memory write port
//       mem_we_o, mem_addr_o,
//       mem_data_o                sequencer -> memory
// Signal names keep the sequencer's point of view (_o driven by it, _i seen by
// it). The master modport is the sequencer; the slave modport is the
// engine/memory side.
// -----------------------------------------------------------------------------
interface sd_boot_sequencer_if #(
  parameter int MEM_AW = 12
);
  logic              rd_req_o;
  logic [31:0]       rd_addr_o;
  logic              rd_ack_i;
  logic [31:0]       rd_data_i;
  logic              rd_err_i;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;

  modport master (
    output rd_req_o, rd_addr_o, mem_we_o, mem_addr_o, mem_data_o,
    input  rd_ack_i, rd_data_i, rd_err_i
  );

  modport slave (
    input  rd_req_o, rd_addr_o, mem_we_o, mem_addr_o, mem_data_o,
    output rd_ack_i, rd_data_i, rd_err_i
  );
endinterface

// File: rtl/sd_boot_sequencer.sv
// -----------------------------------------------------------------------------
// sd_boot_sequencer
//
// Boot-time loader: walks a contiguous image on the SD card one 32-bit word at
// a time through the SD read engine, writes each word into program memory and
// holds the processor in reset until the image is loaded. A stalled or failing
// word is retried up to MAX_RETRY times before the error state.
//
// Optional feature (compile-time macro BOOT_CHECKSUM_EN): the last image word
// is an expected 32-bit wrapping sum of all preceding words; a mismatch ends in
// ERR instead of DONE. Without the macro checksum_o is tied to 0.
//
// Ports
//   boot_clk_i     clock, everything on the rising edge
//   boot_rst_n_i   asynchronous active-low reset
//   start_i        start pulse (honoured in IDLE, DONE, ERR)
//   base_addr_i    SD address of word 0, sampled on start
//   word_count_i   number of words, sampled on start
//   bus            sd_boot_sequencer_if.master (SD read handshake + mem write)
//   busy_o         load in progress
//   done_o         image loaded
//   error_o        retries exhausted (or checksum mismatch)
//   cpu_rst_n_o    processor reset, released only in DONE
//   checksum_o     running checksum (0 when the feature is compiled out)
// -----------------------------------------------------------------------------
module sd_boot_sequencer #(
  parameter int unsigned ADDR_STEP   = 4,
  parameter int          MEM_AW      = 12,
  parameter logic [19:0] TIMEOUT_CYC = 20'd500000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic               boot_clk_i,
  input  logic               boot_rst_n_i,
  input  logic               start_i,
  input  logic [31:0]        base_addr_i,
  input  logic [MEM_AW:0]    word_count_i,
  sd_boot_sequencer_if.master bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic               cpu_rst_n_o,
  output logic [31:0]        checksum_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_WAIT, ST_WRITE, ST_NEXT, ST_DONE, ST_ERR
  } state_t;

  // One spare count above MAX_RETRY so the increment on the final failure
  // never wraps.
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  state_t              state_q, state_d;
  logic [31:0]         base_q;
  logic [MEM_AW:0]     count_q;
  logic [MEM_AW:0]     index_q;
  logic [MEM_AW:0]     index_next;
  logic [RETRY_W-1:0]  retry_q;
  logic [19:0]         tmo_q;
  logic [31:0]         data_q;
  logic                regap_q;   // REQ entered from a failed attempt

  logic start_ok;
  logic ack_ok;
  logic fail;
  logic timeout;
  logic last_word;
  logic retry_exhausted;
  logic sum_ok;

  assign start_ok        = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign ack_ok          = bus.rd_ack_i && !bus.rd_err_i;
  assign timeout         = (tmo_q == TIMEOUT_CYC - 20'd1);
  // Ack has priority: a good ack in the timeout cycle is not a failure.
  assign fail            = (bus.rd_ack_i && bus.rd_err_i) || (timeout && !bus.rd_ack_i);
  assign index_next      = index_q + {{MEM_AW{1'b0}}, 1'b1};
  assign last_word       = (index_next == count_q);
  assign retry_exhausted = (retry_q == RETRY_W'(MAX_RETRY));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge boot_clk_i or negedge boot_rst_n_i) begin
    if (!boot_rst_n_i) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) state_d = (word_count_i == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (ack_ok)    state_d = ST_WRITE;
        else if (fail) state_d = retry_exhausted ? ST_ERR : ST_REQ;
      end
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        if (last_word) state_d = sum_ok ? ST_DONE : ST_ERR;
        else           state_d = ST_REQ;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from state; rd_req_o is held low in the REQ cycle of a
  // retry so every attempt shows up as a fresh rising edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.rd_req_o   = ((state_q == ST_REQ) && !regap_q) || (state_q == ST_WAIT);
    bus.rd_addr_o  = base_q + 32'(index_q) * 32'(ADDR_STEP);
    bus.mem_we_o   = (state_q == ST_WRITE);
    bus.mem_addr_o = index_q[MEM_AW-1:0];
    bus.mem_data_o = data_q;
    busy_o         = state_q inside {ST_REQ, ST_WAIT, ST_WRITE, ST_NEXT};
    done_o         = (state_q == ST_DONE);
    error_o        = (state_q == ST_ERR);
    cpu_rst_n_o    = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: load parameters, word index, retry and timeout counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge boot_clk_i or negedge boot_rst_n_i) begin
    if (!boot_rst_n_i) begin
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      regap_q <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q  <= base_addr_i;
        count_q <= word_count_i;
        index_q <= '0;
        retry_q <= '0;
        regap_q <= 1'b0;
      end
      unique case (state_q)
        ST_REQ: begin
          tmo_q   <= '0;
          regap_q <= 1'b0;
        end
        ST_WAIT: begin
          if (ack_ok) begin
            data_q <= bus.rd_data_i;
          end else if (fail) begin
            retry_q <= retry_q + RETRY_W'(1);
            regap_q <= 1'b1;
          end
          // Saturating: a huge TIMEOUT_CYC must never wrap back to zero.
          if (tmo_q != '1) tmo_q <= tmo_q + 20'd1;
        end
        ST_NEXT: begin
          index_q <= index_next;
          retry_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional checksum: sum of words 0..count-2, compared against the last word
  // ---------------------------------------------------------------------------
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge boot_clk_i or negedge boot_rst_n_i) begin
    if (!boot_rst_n_i) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if ((state_q == ST_WRITE) && !last_word) begin
      csum_q <= csum_q + data_q;
    end
  end

  // In NEXT of the last word data_q still holds that word: the expected sum.
  assign sum_ok     = (data_q == csum_q);
  assign checksum_o = csum_q;
`else
  assign sum_ok     = 1'b1;
  assign checksum_o = '0;
`endif

endmodule
